bp_axil_master_arbiter: RTL

//  Shares the single outgoing AXI4-Lite master port (m_axil_*) between num_req_p AXI4-Lite requesters.

---
 rtl/bp_axil_master_arbiter.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/bp_axil_master_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master port among num_req_p requesters, one transaction in flight.
// Optional response watchdog (SLVERR + flush of the late response) enabled by defining AXIL_ARB_TIMEOUT_EN.
module bp_axil_master_arbiter #(
    parameter int num_req_p         = 2,
    parameter int axil_addr_width_p = 32,
    parameter int axil_data_width_p = 32,
    parameter int timeout_p         = 1024
) (
    input  logic                                              clk_i,
    input  logic                                              reset_n_i,
    input  logic [num_req_p-1:0][axil_addr_width_p-1:0]       s_axil_awaddr_i,
    input  logic [num_req_p-1:0][2:0]                         s_axil_awprot_i,
    input  logic [num_req_p-1:0]                              s_axil_awvalid_i,
    output logic [num_req_p-1:0]                              s_axil_awready_o,
    input  logic [num_req_p-1:0][axil_data_width_p-1:0]       s_axil_wdata_i,
    input  logic [num_req_p-1:0][axil_data_width_p/8-1:0]     s_axil_wstrb_i,
    input  logic [num_req_p-1:0]                              s_axil_wvalid_i,
    output logic [num_req_p-1:0]                              s_axil_wready_o,
    output logic [num_req_p-1:0][1:0]                         s_axil_bresp_o,
    output logic [num_req_p-1:0]                              s_axil_bvalid_o,
    input  logic [num_req_p-1:0]                              s_axil_bready_i,
    input  logic [num_req_p-1:0][axil_addr_width_p-1:0]       s_axil_araddr_i,
    input  logic [num_req_p-1:0][2:0]                         s_axil_arprot_i,
    input  logic [num_req_p-1:0]                              s_axil_arvalid_i,
    output logic [num_req_p-1:0]                              s_axil_arready_o,
    output logic [num_req_p-1:0][axil_data_width_p-1:0]       s_axil_rdata_o,
    output logic [num_req_p-1:0][1:0]                         s_axil_rresp_o,
    output logic [num_req_p-1:0]                              s_axil_rvalid_o,
    input  logic [num_req_p-1:0]                              s_axil_rready_i,
    output logic [axil_addr_width_p-1:0]                      m_axil_awaddr_o,
    output logic [2:0]                                        m_axil_awprot_o,
    output logic                                              m_axil_awvalid_o,
    input  logic                                              m_axil_awready_i,
    output logic [axil_data_width_p-1:0]                      m_axil_wdata_o,
    output logic [axil_data_width_p/8-1:0]                    m_axil_wstrb_o,
    output logic                                              m_axil_wvalid_o,
    input  logic                                              m_axil_wready_i,
    input  logic [1:0]                                        m_axil_bresp_i,
    input  logic                                              m_axil_bvalid_i,
    output logic                                              m_axil_bready_o,
    output logic [axil_addr_width_p-1:0]                      m_axil_araddr_o,
    output logic [2:0]                                        m_axil_arprot_o,
    output logic                                              m_axil_arvalid_o,
    input  logic                                              m_axil_arready_i,
    input  logic [axil_data_width_p-1:0]                      m_axil_rdata_i,
    input  logic [1:0]                                        m_axil_rresp_i,
    input  logic                                              m_axil_rvalid_i,
    output logic                                              m_axil_rready_o
);
    localparam int gw_lp = $clog2(num_req_p);

`ifdef AXIL_ARB_TIMEOUT_EN
    typedef enum logic [2:0] {IDLE, W_ADDR, W_RESP, R_ADDR, R_RESP, T_ERR, FLUSH} state_e;
    localparam int cnt_w_lp = $clog2(timeout_p + 1);
    logic [cnt_w_lp-1:0] cnt_q, cnt_d;
    logic                is_wr_q, is_wr_d;
`else
    typedef enum logic [2:0] {IDLE, W_ADDR, W_RESP, R_ADDR, R_RESP} state_e;
`endif

    state_e             state_q, state_d;
    logic [gw_lp-1:0]   grant_q, grant_d, pick;
    logic               aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic               aw_hs, w_hs;
    logic [num_req_p-1:0] req;
    int                 idx;

    assign req = s_axil_awvalid_i | s_axil_arvalid_i;

    // First requester strictly after the last grant wins; the last grant is only re-picked if it is alone.
    always_comb begin
        pick = grant_q;
        idx  = 0;
        for (int k = num_req_p; k >= 1; k--) begin
            idx = (int'(grant_q) + k) % num_req_p;
            if (req[idx]) pick = idx[gw_lp-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= IDLE;
            grant_q   <= gw_lp'(num_req_p - 1);
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
`ifdef AXIL_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            is_wr_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
`ifdef AXIL_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            is_wr_q   <= is_wr_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        aw_hs     = 1'b0;
        w_hs      = 1'b0;
`ifdef AXIL_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        is_wr_d   = is_wr_q;
`endif
        s_axil_awready_o = '0;
        s_axil_wready_o  = '0;
        s_axil_bresp_o   = '0;
        s_axil_bvalid_o  = '0;
        s_axil_arready_o = '0;
        s_axil_rdata_o   = '0;
        s_axil_rresp_o   = '0;
        s_axil_rvalid_o  = '0;
        m_axil_awaddr_o  = '0;
        m_axil_awprot_o  = '0;
        m_axil_awvalid_o = 1'b0;
        m_axil_wdata_o   = '0;
        m_axil_wstrb_o   = '0;
        m_axil_wvalid_o  = 1'b0;
        m_axil_bready_o  = 1'b0;
        m_axil_araddr_o  = '0;
        m_axil_arprot_o  = '0;
        m_axil_arvalid_o = 1'b0;
        m_axil_rready_o  = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d = pick;
                    state_d = s_axil_awvalid_i[pick] ? W_ADDR : R_ADDR;
`ifdef AXIL_ARB_TIMEOUT_EN
                    is_wr_d = s_axil_awvalid_i[pick];
`endif
                end
            end
            W_ADDR: begin
                // AW and W complete independently; done flags mask the channel after its handshake.
                m_axil_awaddr_o           = s_axil_awaddr_i[grant_q];
                m_axil_awprot_o           = s_axil_awprot_i[grant_q];
                m_axil_awvalid_o          = s_axil_awvalid_i[grant_q] & ~aw_done_q;
                s_axil_awready_o[grant_q] = m_axil_awready_i & ~aw_done_q;
                m_axil_wdata_o            = s_axil_wdata_i[grant_q];
                m_axil_wstrb_o            = s_axil_wstrb_i[grant_q];
                m_axil_wvalid_o           = s_axil_wvalid_i[grant_q] & ~w_done_q;
                s_axil_wready_o[grant_q]  = m_axil_wready_i & ~w_done_q;
                aw_hs     = s_axil_awvalid_i[grant_q] & ~aw_done_q & m_axil_awready_i;
                w_hs      = s_axil_wvalid_i[grant_q] & ~w_done_q & m_axil_wready_i;
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = W_RESP;
                end
            end
            W_RESP: begin
                m_axil_bready_o          = s_axil_bready_i[grant_q];
                s_axil_bvalid_o[grant_q] = m_axil_bvalid_i;
                s_axil_bresp_o[grant_q]  = m_axil_bresp_i;
                if (m_axil_bvalid_i && s_axil_bready_i[grant_q]) state_d = IDLE;
`ifdef AXIL_ARB_TIMEOUT_EN
                else if (!m_axil_bvalid_i) begin
                    if (cnt_q == cnt_w_lp'(timeout_p - 1)) state_d = T_ERR;
                    else cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            R_ADDR: begin
                m_axil_araddr_o           = s_axil_araddr_i[grant_q];
                m_axil_arprot_o           = s_axil_arprot_i[grant_q];
                m_axil_arvalid_o          = s_axil_arvalid_i[grant_q];
                s_axil_arready_o[grant_q] = m_axil_arready_i;
                if (s_axil_arvalid_i[grant_q] && m_axil_arready_i) state_d = R_RESP;
            end
            R_RESP: begin
                m_axil_rready_o          = s_axil_rready_i[grant_q];
                s_axil_rvalid_o[grant_q] = m_axil_rvalid_i;
                s_axil_rdata_o[grant_q]  = m_axil_rdata_i;
                s_axil_rresp_o[grant_q]  = m_axil_rresp_i;
                if (m_axil_rvalid_i && s_axil_rready_i[grant_q]) state_d = IDLE;
`ifdef AXIL_ARB_TIMEOUT_EN
                else if (!m_axil_rvalid_i) begin
                    if (cnt_q == cnt_w_lp'(timeout_p - 1)) state_d = T_ERR;
                    else cnt_d = cnt_q + 1'b1;
                end
`endif
            end
`ifdef AXIL_ARB_TIMEOUT_EN
            T_ERR: begin
                // Synthesised SLVERR; the master keeps its late response pending until FLUSH sinks it.
                if (is_wr_q) begin
                    s_axil_bvalid_o[grant_q] = 1'b1;
                    s_axil_bresp_o[grant_q]  = 2'b10;
                    if (s_axil_bready_i[grant_q]) state_d = FLUSH;
                end else begin
                    s_axil_rvalid_o[grant_q] = 1'b1;
                    s_axil_rresp_o[grant_q]  = 2'b10;
                    if (s_axil_rready_i[grant_q]) state_d = FLUSH;
                end
            end
            FLUSH: begin
                m_axil_bready_o = is_wr_q;
                m_axil_rready_o = ~is_wr_q;
                if (is_wr_q ? m_axil_bvalid_i : m_axil_rvalid_i) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase

`ifdef AXIL_ARB_TIMEOUT_EN
        if (state_d != state_q) cnt_d = '0;
`endif
    end
endmodule
